// File: rtl/eight_y.sv
// Sine-weighted PWM generator: one 32-step sine table entry per carrier period sets the duty cycle.
// Optional macro EIGHT_Y_ENABLE_SYNC_EN adds a 2-flop synchronizer on Enable_SW_1.
module eight_y #(
    parameter int unsigned PWM_PERIOD = 250
) (
    input  logic sysclk,
    input  logic rst_n,
    input  logic Enable_SW_1,
    output logic Pulse
);

    localparam logic [15:0] LP_PERIOD = 16'(PWM_PERIOD);
    localparam logic [15:0] LP_LAST   = 16'(PWM_PERIOD - 1);

    logic        w_en;
    logic [7:0]  w_sin;
    logic [23:0] w_prod;
    logic [15:0] w_thr_now;
    logic [15:0] w_thr;
    logic        w_cnt_zero;

    logic [15:0] r_cnt;
    logic [4:0]  r_idx;
    logic [15:0] r_thr;
    logic        r_pulse;

`ifdef EIGHT_Y_ENABLE_SYNC_EN
    logic [1:0]  r_en_sync;

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_en_sync <= 2'b00;
        end else begin
            r_en_sync <= {r_en_sync[0], Enable_SW_1};
        end
    end

    assign w_en = r_en_sync[1];
`else
    assign w_en = Enable_SW_1;
`endif

    // round(128 + 127*sin(2*pi*k/32))
    always_comb begin
        w_sin = 8'd128;
        case (r_idx)
            5'd0:  w_sin = 8'd128;
            5'd1:  w_sin = 8'd153;
            5'd2:  w_sin = 8'd177;
            5'd3:  w_sin = 8'd199;
            5'd4:  w_sin = 8'd218;
            5'd5:  w_sin = 8'd234;
            5'd6:  w_sin = 8'd245;
            5'd7:  w_sin = 8'd253;
            5'd8:  w_sin = 8'd255;
            5'd9:  w_sin = 8'd253;
            5'd10: w_sin = 8'd245;
            5'd11: w_sin = 8'd234;
            5'd12: w_sin = 8'd218;
            5'd13: w_sin = 8'd199;
            5'd14: w_sin = 8'd177;
            5'd15: w_sin = 8'd153;
            5'd16: w_sin = 8'd128;
            5'd17: w_sin = 8'd103;
            5'd18: w_sin = 8'd79;
            5'd19: w_sin = 8'd57;
            5'd20: w_sin = 8'd38;
            5'd21: w_sin = 8'd22;
            5'd22: w_sin = 8'd11;
            5'd23: w_sin = 8'd3;
            5'd24: w_sin = 8'd1;
            5'd25: w_sin = 8'd3;
            5'd26: w_sin = 8'd11;
            5'd27: w_sin = 8'd22;
            5'd28: w_sin = 8'd38;
            5'd29: w_sin = 8'd57;
            5'd30: w_sin = 8'd79;
            5'd31: w_sin = 8'd103;
            default: w_sin = 8'd128;
        endcase
    end

    assign w_prod     = 24'(w_sin) * 24'(LP_PERIOD);
    assign w_thr_now  = 16'(w_prod >> 8);
    assign w_cnt_zero = (r_cnt == 16'd0);
    // The first cycle of a period compares against the freshly computed threshold.
    assign w_thr      = w_cnt_zero ? w_thr_now : r_thr;

    always_ff @(posedge sysclk) begin
        if (!rst_n || !w_en) begin
            r_cnt   <= 16'd0;
            r_idx   <= 5'd0;
            r_thr   <= 16'd0;
            r_pulse <= 1'b0;
        end else begin
            r_pulse <= (r_cnt < w_thr);
            if (w_cnt_zero) begin
                r_thr <= w_thr_now;
            end
            if (r_cnt == LP_LAST) begin
                r_cnt <= 16'd0;
                r_idx <= r_idx + 5'd1;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign Pulse = r_pulse;

endmodule

// File: tb/tb_eight_y.sv
// Directed bench for eight_y: two instances (period 250 and 100), period-by-period duty checks.
module tb_eight_y;

`ifdef EIGHT_Y_ENABLE_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en_a  = 1'b0;
    logic en_b  = 1'b0;
    logic pulse_a;
    logic pulse_b;

    int     n_chk  = 0;
    int     n_pass = 0;
    longint cyc    = 0;

    // round(128+127*sin(2*pi*k/32)) * 250 >> 8, worked out by hand
    int exp_thr [32] = '{125, 149, 172, 194, 212, 228, 239, 247,
                         249, 247, 239, 228, 212, 194, 172, 149,
                         125, 100,  77,  55,  37,  21,  10,   2,
                           0,   2,  10,  21,  37,  55,  77, 100};

    always #10 clk = ~clk;

    eight_y #(.PWM_PERIOD(250)) u_dut (
        .sysclk      (clk),
        .rst_n       (rst_n),
        .Enable_SW_1 (en_a),
        .Pulse       (pulse_a)
    );

    eight_y #(.PWM_PERIOD(100)) u_dut100 (
        .sysclk      (clk),
        .rst_n       (rst_n),
        .Enable_SW_1 (en_b),
        .Pulse       (pulse_b)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Samples n cycles: leading low count, first high run length, total highs, cycle of first high.
    task automatic run_window(input int n, input bit sel, output int lead, output int run,
                              output int tot, output longint first_hi);
        int   ph;
        logic p;
        ph = 0; lead = 0; run = 0; tot = 0; first_hi = -1;
        for (int i = 0; i < n; i++) begin
            tick();
            p = sel ? pulse_b : pulse_a;
            if (p) begin
                tot++;
                if (first_hi < 0) first_hi = cyc;
            end
            case (ph)
                0: if (p) begin ph = 1; run = 1; end else lead++;
                1: if (p) run++; else ph = 2;
                default: ;
            endcase
        end
    endtask

    initial begin
        int     lead, run, tot, e, hi_early, hi_late;
        longint fh, t0, t32;
        t32 = -1;

        rst_n = 1'b0; en_a = 1'b1; en_b = 1'b0;
        repeat (5) tick();
        chk("rst_pulse", pulse_a, 0);
        chk("rst_cnt", u_dut.r_cnt, 0);
        chk("rst_idx", u_dut.r_idx, 0);

        rst_n = 1'b1;
        run_window(LAT + 250, 1'b0, lead, run, tot, t0);
        chk("p0_lead", lead, LAT);
        chk("p0_run", run, 125);
        chk("p0_tot", tot, 125);

        for (int k = 1; k <= 32; k++) begin
            run_window(250, 1'b0, lead, run, tot, fh);
            e = exp_thr[k % 32];
            chk($sformatf("p%0d_tot", k), tot, e);
            chk($sformatf("p%0d_run", k), run, e);
            chk($sformatf("p%0d_lead", k), lead, (e == 0) ? 250 : 0);
            if (k == 32) t32 = fh;
        end
        chk("envelope", t32 - t0, 8000);

        repeat (120) tick();
        chk("mid_pulse_hi", pulse_a, 1);
        en_a = 1'b0;
        hi_early = 0; hi_late = 0;
        for (int i = 0; i < 4000; i++) begin
            tick();
            if (pulse_a) begin
                if (i < LAT) hi_early++;
                else hi_late++;
            end
        end
        chk("dis_early_hi", hi_early, LAT);
        chk("dis_late_hi", hi_late, 0);
        chk("dis_cnt", u_dut.r_cnt, 0);
        chk("dis_idx", u_dut.r_idx, 0);

        en_a = 1'b1;
        run_window(LAT + 250, 1'b0, lead, run, tot, fh);
        chk("re_lead", lead, LAT);
        chk("re_run", run, 125);
        chk("re_tot", tot, 125);
        run_window(250, 1'b0, lead, run, tot, fh);
        chk("re_p1_tot", tot, 149);

        en_b = 1'b1;
        run_window(LAT + 100, 1'b1, lead, run, tot, fh);
        chk("b_p0_lead", lead, LAT);
        chk("b_p0_run", run, 50);
        chk("b_p0_tot", tot, 50);
        for (int k = 1; k <= 24; k++) begin
            run_window(100, 1'b1, lead, run, tot, fh);
            if (k == 8) begin
                chk("b_p8_run", run, 99);
                chk("b_p8_tot", tot, 99);
                chk("b_p8_lead", lead, 0);
            end
            if (k == 24) begin
                chk("b_p24_tot", tot, 0);
                chk("b_p24_lead", lead, 100);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
